dram_arbiter: RTL and testbench

Two-port arbiter that shares the single DRAM controller between the RV32I instruction-fetch port and the load/store data port. It grants one requester at a time, holds the controller's level-sensitive `re`/`we` inputs for exactly one transaction, and returns the read data with a one-cycle acknowledge. A starvation limit and a response watchdog bound the wait on either side. It sits between the core's memory ports and the DRAM controller's CPU interface.

---
 rtl/dram_arb_pkg.sv | 17 +
 rtl/dram_arb_if.sv | 54 +++++
 rtl/dram_arb_pick.sv | 29 ++
 rtl/dram_arbiter.sv | 119 +++++++++++
 tb/tb_dram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the ifetch/data DRAM arbiter.
// Owner encoding matches the owner status output.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_STARVE_MAX = 4;
  localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/dram_arb_if.sv
// Core-side and controller-side signals of the DRAM arbiter.
// The arbiter takes the slave view; core and controller drive master.
interface dram_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ack;
  logic                  i_err;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ack;
  logic                  d_err;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_re;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  logic                  busy;
  logic                  owner;

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  i_ack, i_err, i_rdata,
    input  d_ack, d_err, d_rdata,
    input  mem_addr, mem_wdata,
    input  mem_re, mem_we,
    input  busy, owner
  );

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output i_ack, i_err, i_rdata,
    output d_ack, d_err, d_rdata,
    output mem_addr, mem_wdata,
    output mem_re, mem_we,
    output busy, owner
  );

endinterface

// File: rtl/dram_arb_pick.sv
// Combinational grant decision: data first, ifetch when
// the starvation limit is reached or data is idle.
module dram_arb_pick
  import dram_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic starve_lim,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWN_I;
    unique case (1'b1)
      i_req & (starve_lim | ~d_req): begin
        grant_valid = 1'b1;
        grant_owner = OWN_I;
      end
      d_req & ~(i_req & starve_lim): begin
        grant_valid = 1'b1;
        grant_owner = OWN_D;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one DRAM controller between ifetch and data ports,
// one transaction at a time, with starvation and timeout bounds.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic      clk,
  input  logic      reset,
  dram_arb_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t                state;
  logic                  lat_we;
  logic [7:0]            tmo_cnt;
  logic [SW-1:0]         starve_cnt;
  logic                  starve_lim;
  logic                  grant_valid;
  logic                  grant_owner;
  logic                  tmo_hit;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign starve_lim = starve_cnt == SW'(STARVE_MAX);
  assign tmo_hit    = tmo_cnt == 8'(TIMEOUT);
  assign gnt_addr   = (grant_owner == OWN_D) ?
                      bus.d_addr : bus.i_addr;
  assign rsp_data   = (lat_we | ~bus.mem_ready) ?
                      '0 : bus.mem_rdata;

  // Drop re/we in the ready cycle so the controller does not restart
  assign bus.mem_re = (state == BUSY) & ~lat_we
                      & ~bus.mem_ready;
  assign bus.mem_we = (state == BUSY) & lat_we
                      & ~bus.mem_ready;

  dram_arb_pick u_pick (
    .i_req       (bus.i_req),
    .d_req       (bus.d_req),
    .starve_lim  (starve_lim),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lat_we        <= 1'b0;
      tmo_cnt       <= '0;
      starve_cnt    <= '0;
      bus.i_ack     <= 1'b0;
      bus.i_err     <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_ack     <= 1'b0;
      bus.d_err     <= 1'b0;
      bus.d_rdata   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
      bus.owner     <= OWN_I;
    end else begin
      bus.i_ack   <= 1'b0;
      bus.i_err   <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_ack   <= 1'b0;
      bus.d_err   <= 1'b0;
      bus.d_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            state        <= BUSY;
            bus.busy     <= 1'b1;
            bus.owner    <= grant_owner;
            bus.mem_addr <= gnt_addr;
            bus.mem_wdata <= (grant_owner == OWN_D) ?
                             bus.d_wdata : '0;
            lat_we  <= (grant_owner == OWN_D) & bus.d_we;
            tmo_cnt <= '0;
            if (grant_owner == OWN_D && bus.i_req) begin
              if (!starve_lim)
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        BUSY: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (bus.mem_ready || tmo_hit) begin
            state <= RESP;
            if (bus.owner == OWN_D) begin
              bus.d_ack   <= 1'b1;
              bus.d_err   <= ~bus.mem_ready;
              bus.d_rdata <= rsp_data;
            end else begin
              bus.i_ack   <= 1'b1;
              bus.i_err   <= ~bus.mem_ready;
              bus.i_rdata <= rsp_data;
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: transaction table plus
// starvation, timeout, reset-abort and back-to-back sequences.
module tb_dram_arbiter;

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          dly;
    logic        exp_own;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  dram_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dram_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .STARVE_MAX (4),
    .TIMEOUT    (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   ok;
    logic ere;
    logic ewe;
    ewe = (v.exp_own == 1'b1) & v.dwe;
    ere = ~ewe;
    bus.i_req   = v.ireq;
    bus.i_addr  = v.iaddr;
    bus.d_req   = v.dreq;
    bus.d_we    = v.dwe;
    bus.d_addr  = v.daddr;
    bus.d_wdata = v.wdata;
    tick();
    chk({tag, "_busy"}, bus.busy, 1'b1);
    chk({tag, "_owner"}, bus.owner, v.exp_own);
    chk({tag, "_addr"}, bus.mem_addr, v.exp_addr);
    if (ewe)
      chk({tag, "_wdata"}, bus.mem_wdata, v.wdata);
    ok = 0;
    for (int k = 1; k < v.dly; k++) begin
      if (bus.mem_re == ere && bus.mem_we == ewe &&
          !bus.i_ack && !bus.d_ack)
        ok++;
      tick();
    end
    chk({tag, "_window"}, ok, v.dly - 1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = v.mrdata;
    #1;
    chk({tag, "_rdy_rewe"}, {bus.mem_re, bus.mem_we}, 2'b00);
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    chk({tag, "_i_ack"}, bus.i_ack, v.exp_own == 1'b0);
    chk({tag, "_d_ack"}, bus.d_ack, v.exp_own == 1'b1);
    chk({tag, "_err"}, {bus.i_err, bus.d_err}, 2'b00);
    chk({tag, "_i_rdata"}, bus.i_rdata,
        (v.exp_own == 1'b0) ? v.exp_rdata : 32'h0);
    chk({tag, "_d_rdata"}, bus.d_rdata,
        (v.exp_own == 1'b1) ? v.exp_rdata : 32'h0);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
    chk({tag, "_idle"},
        {bus.busy, bus.i_ack, bus.d_ack}, 3'b000);
  endtask

  vec_t vecs[5];
  vec_t fresh;

  initial begin
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    vecs[0] = '{1, 0, 0, 32'h100, 32'h0, 32'h0,
                32'hDEADBEEF, 5, 1'b0, 32'h100, 32'hDEADBEEF};
    vecs[1] = '{0, 1, 1, 32'h0, 32'h2000, 32'h12345678,
                32'h0000FFFF, 3, 1'b1, 32'h2000, 32'h0};
    vecs[2] = '{0, 1, 0, 32'h0, 32'h3004, 32'h0,
                32'hCAFEF00D, 1, 1'b1, 32'h3004, 32'hCAFEF00D};
    vecs[3] = '{1, 1, 0, 32'h40, 32'h50, 32'h0,
                32'h0BADC0DE, 2, 1'b1, 32'h50, 32'h0BADC0DE};
    vecs[4] = '{1, 0, 0, 32'h44, 32'h0, 32'h0,
                32'h00000013, 1, 1'b0, 32'h44, 32'h00000013};
    fresh   = '{1, 0, 0, 32'h88, 32'h0, 32'h0,
                32'h600DF00D, 2, 1'b0, 32'h88, 32'h600DF00D};

    repeat (2) tick();
    chk("rst_busy_owner", {bus.busy, bus.owner}, 2'b00);
    chk("rst_rewe", {bus.mem_re, bus.mem_we}, 2'b00);
    chk("rst_acks", {bus.i_ack, bus.d_ack,
                     bus.i_err, bus.d_err}, 4'h0);
    chk("rst_mem", {bus.mem_addr, bus.mem_wdata}, 64'h0);
    chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      run_txn(vecs[i], $sformatf("v%0d", i));

    // Reset while BUSY aborts with no ack
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h80;
    tick();
    tick();
    chk("rb_re_before", bus.mem_re, 1'b1);
    reset = 1'b1;
    tick();
    chk("rb_idle", {bus.busy, bus.mem_re, bus.mem_we}, 3'b000);
    chk("rb_noack", {bus.i_ack, bus.d_ack}, 2'b00);
    bus.i_req = 1'b0;
    reset = 1'b0;
    tick();
    run_txn(fresh, "rb_fresh");

    // Both held: data wins until the starvation limit
    begin
      int         cyc;
      int         ng;
      int         dup;
      logic [0:9] got;
      logic [0:9] exp_order;
      exp_order = 10'b1111011110;
      got = '0;
      cyc = 0;
      ng = 0;
      dup = 0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h400;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h800;
      while (ng < 10 && cyc < 200) begin
        bus.mem_ready = 1'b0;
        #1;
        if (bus.i_ack && bus.d_ack)
          dup++;
        if (bus.i_ack || bus.d_ack) begin
          got[ng] = bus.d_ack;
          ng++;
        end
        bus.mem_ready = bus.mem_re | bus.mem_we;
        tick();
        cyc++;
      end
      bus.mem_ready = 1'b0;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      chk("sv_grants", ng, 10);
      for (int g = 0; g < 10; g++)
        chk($sformatf("sv_order%0d", g), got[g], exp_order[g]);
      chk("sv_dup", dup, 0);
      repeat (2) tick();
    end

    // Timeout on a data write
    begin
      int n;
      int bc;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h40;
      bus.d_wdata = 32'h55;
      tick();
      n = 0;
      bc = 0;
      while (!bus.d_ack && n < 400) begin
        if (bus.mem_we && bus.busy)
          bc++;
        tick();
        n++;
      end
      chk("to_len", bc, 256);
      chk("to_ack_err", {bus.d_ack, bus.d_err}, 2'b11);
      chk("to_rdata", bus.d_rdata, 32'h0);
      chk("to_we_low", bus.mem_we, 1'b0);
      chk("to_i_quiet", {bus.i_ack, bus.i_err}, 2'b00);
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      tick();
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      chk("to_late_rdy", {bus.busy, bus.d_ack}, 2'b00);
    end

    // Back-to-back ifetch reads
    begin
      int   na;
      int   nwin;
      int   idle;
      int   rc;
      logic prev_re;
      logic acked;
      logic [31:0] adr;
      na = 0;
      nwin = 0;
      idle = 0;
      rc = 0;
      prev_re = 1'b0;
      acked = 1'b0;
      adr = 32'h200;
      bus.i_req  = 1'b1;
      bus.i_addr = adr;
      for (int c = 0; c < 40; c++) begin
        bus.mem_ready = 1'b0;
        #1;
        if (acked) begin
          acked = 1'b0;
          if (na < 3) begin
            adr = adr + 32'h4;
            bus.i_addr = adr;
          end else begin
            bus.i_req = 1'b0;
          end
        end
        if (na >= 1 && na < 3 && !bus.busy)
          idle++;
        if (bus.mem_re && !prev_re)
          nwin++;
        prev_re = bus.mem_re;
        if (bus.i_ack) begin
          chk($sformatf("bb_rdata%0d", na), bus.i_rdata,
              (32'h200 + 32'(na) * 4) ^ 32'hA5A50000);
          na++;
          acked = 1'b1;
        end
        if (bus.mem_re) begin
          rc++;
          if (rc == 2) begin
            rc = 0;
            bus.mem_ready = 1'b1;
            bus.mem_rdata = bus.mem_addr ^ 32'hA5A50000;
          end
        end
        tick();
      end
      bus.mem_ready = 1'b0;
      chk("bb_acks", na, 3);
      chk("bb_windows", nwin, 3);
      chk("bb_idle_gap", idle, 2);
      chk("bb_d_quiet", bus.d_ack, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
